// File: rtl/bit_stuffing.sv
// CAN receive-path bit-stuffing monitor: counts equal bits at each sample point,
// flags the following stuff bit and reports a stuff error when its polarity is wrong.
module bit_stuffing #(
  parameter int unsigned STUFF_LEN = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic samplePoint,
  input  logic canRX,
  input  logic bsOnOff,
  output logic stuffing,
  output logic bsError
);

  localparam logic [3:0] LP_STUFF_LEN = 4'(STUFF_LEN);

  logic       r_sp_prev;
  logic [3:0] r_count;
  logic       r_last_bit;
  logic       r_stuffing;
  logic       r_bs_error;

  logic       w_sample;
  logic [3:0] w_count_inc;
  logic [3:0] w_count_nxt;
  logic       w_last_bit_nxt;
  logic       w_stuffing_nxt;
  logic       w_bs_error_nxt;

  assign w_sample    = samplePoint & ~r_sp_prev;
  assign w_count_inc = r_count + 4'd1;

  always_comb begin
    w_count_nxt    = r_count;
    w_last_bit_nxt = r_last_bit;
    w_stuffing_nxt = r_stuffing;
    w_bs_error_nxt = r_bs_error;
    if (!bsOnOff) begin
      // disable wins over a coincident sample event
      w_count_nxt    = 4'd0;
      w_last_bit_nxt = 1'b1;
      w_stuffing_nxt = 1'b0;
      w_bs_error_nxt = 1'b0;
    end else if (w_sample) begin
      if (r_stuffing) begin
        // the stuff bit (good or bad) starts the next run
        w_bs_error_nxt = (canRX == r_last_bit);
        w_stuffing_nxt = 1'b0;
        w_count_nxt    = 4'd1;
        w_last_bit_nxt = canRX;
      end else if (r_count == 4'd0) begin
        w_count_nxt    = 4'd1;
        w_last_bit_nxt = canRX;
        w_bs_error_nxt = 1'b0;
      end else if (canRX == r_last_bit) begin
        w_count_nxt    = w_count_inc;
        w_bs_error_nxt = 1'b0;
        if (w_count_inc == LP_STUFF_LEN) w_stuffing_nxt = 1'b1;
      end else begin
        w_count_nxt    = 4'd1;
        w_last_bit_nxt = canRX;
        w_bs_error_nxt = 1'b0;
      end
    end
  end

  // r_sp_prev resets high so a strobe already high at reset release is not a sample
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sp_prev  <= 1'b1;
      r_count    <= 4'd0;
      r_last_bit <= 1'b1;
      r_stuffing <= 1'b0;
      r_bs_error <= 1'b0;
    end else begin
      r_sp_prev  <= samplePoint;
      r_count    <= w_count_nxt;
      r_last_bit <= w_last_bit_nxt;
      r_stuffing <= w_stuffing_nxt;
      r_bs_error <= w_bs_error_nxt;
    end
  end

  assign stuffing = r_stuffing;
  assign bsError  = r_bs_error;

endmodule

// File: tb/tb_bit_stuffing.sv
// Self-checking bench for bit_stuffing: a behavioural model predicts outputs per
// sample; predictions are queued at stimulus time and popped when the DUT responds.
module tb_bit_stuffing;

  localparam int unsigned STUFF_LEN = 5;

  logic clock;
  logic reset;
  logic samplePoint;
  logic canRX;
  logic bsOnOff;
  logic stuffing;
  logic bsError;

  bit_stuffing #(.STUFF_LEN(STUFF_LEN)) dut (
    .clock      (clock),
    .reset      (reset),
    .samplePoint(samplePoint),
    .canRX      (canRX),
    .bsOnOff    (bsOnOff),
    .stuffing   (stuffing),
    .bsError    (bsError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  int   m_count;
  logic m_last;
  logic m_stuff;
  logic m_err;

  logic [1:0] exp_q[$];

  task automatic model_clear();
    m_count = 0;
    m_last  = 1'b1;
    m_stuff = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_sample(input logic b);
    if (m_stuff) begin
      m_err   = (b == m_last);
      m_stuff = 1'b0;
      m_count = 1;
      m_last  = b;
    end else if (m_count == 0 || b != m_last) begin
      m_count = 1;
      m_last  = b;
      m_err   = 1'b0;
    end else begin
      m_count = m_count + 1;
      m_err   = 1'b0;
      if (m_count == STUFF_LEN) m_stuff = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // One sample event: strobe high for one clock, low for one clock.
  task automatic do_sample(input logic b);
    logic [1:0] exp;
    canRX       = b;
    samplePoint = 1'b1;
    model_sample(b);
    exp_q.push_back({m_stuff, m_err});
    tick();
    exp = exp_q.pop_front();
    n_total++;
    if ({stuffing, bsError} !== exp)
      $display("FAIL sample_out: got stuffing/bsError=%b%b expected %b%b", stuffing, bsError, exp[1], exp[0]);
    else n_pass++;
    samplePoint = 1'b0;
    tick();
  endtask

  task automatic disable_pulse();
    bsOnOff = 1'b0;
    tick();
    model_clear();
    bsOnOff = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; samplePoint = 1'b0; canRX = 1'b1; bsOnOff = 1'b1;
    model_clear();
    #3;
    n_total++;
    if (stuffing !== 1'b0 || bsError !== 1'b0)
      $display("FAIL reset_state: got %b%b expected 00", stuffing, bsError);
    else n_pass++;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stuff_sequence();
    for (int i = 0; i < 5; i++) do_sample(1'b1);
    n_total++;
    if (stuffing !== 1'b1) $display("FAIL stuff_after_5: got %b expected 1", stuffing);
    else n_pass++;
    do_sample(1'b0);
    n_total++;
    if (stuffing !== 1'b0 || bsError !== 1'b0)
      $display("FAIL valid_stuff_bit: got %b%b expected 00", stuffing, bsError);
    else n_pass++;
    for (int i = 0; i < 4; i++) do_sample(1'b0);
    n_total++;
    if (stuffing !== 1'b1) $display("FAIL stuff_after_10: got %b expected 1", stuffing);
    else n_pass++;
    do_sample(1'b0);
    n_total++;
    if (bsError !== 1'b1 || stuffing !== 1'b0)
      $display("FAIL stuff_error: got stuffing/bsError=%b%b expected 01", stuffing, bsError);
    else n_pass++;
    repeat (3) tick();
    n_total++;
    if (bsError !== 1'b1) $display("FAIL error_hold: got %b expected 1", bsError);
    else n_pass++;
    do_sample(1'b1);
    n_total++;
    if (bsError !== 1'b0) $display("FAIL error_clear: got %b expected 0", bsError);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    disable_pulse();
    for (int i = 0; i < 10; i++) do_sample((i % 2) == 0);
    // last bit was 0 with count 1: four more zeros complete a run of five
    for (int i = 0; i < 3; i++) do_sample(1'b0);
    n_total++;
    if (stuffing !== 1'b0) $display("FAIL alt_run_early: got %b expected 0", stuffing);
    else n_pass++;
    do_sample(1'b0);
    n_total++;
    if (stuffing !== 1'b1) $display("FAIL alt_run_stuff: got %b expected 1", stuffing);
    else n_pass++;
  endtask

  task automatic test_hold();
    logic [1:0] exp;
    disable_pulse();
    canRX       = 1'b1;
    samplePoint = 1'b1;
    model_sample(1'b1);
    exp_q.push_back({m_stuff, m_err});
    tick();
    exp = exp_q.pop_front();
    n_total++;
    if ({stuffing, bsError} !== exp)
      $display("FAIL hold_first: got %b%b expected %b%b", stuffing, bsError, exp[1], exp[0]);
    else n_pass++;
    repeat (7) tick();
    samplePoint = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) do_sample(1'b1);
    n_total++;
    if (stuffing !== 1'b0) $display("FAIL hold_single: got %b expected 0", stuffing);
    else n_pass++;
    do_sample(1'b1);
    n_total++;
    if (stuffing !== 1'b1) $display("FAIL hold_run: got %b expected 1", stuffing);
    else n_pass++;
  endtask

  task automatic test_disable();
    disable_pulse();
    for (int i = 0; i < 4; i++) do_sample(1'b0);
    disable_pulse();
    do_sample(1'b0);
    do_sample(1'b0);
    n_total++;
    if (stuffing !== 1'b0) $display("FAIL disable_count2: got %b expected 0", stuffing);
    else n_pass++;
    for (int i = 0; i < 3; i++) do_sample(1'b0);
    n_total++;
    if (stuffing !== 1'b1) $display("FAIL disable_run: got %b expected 1", stuffing);
    else n_pass++;
    // disable together with a strobe rise: the disable wins and clears stuffing
    bsOnOff = 1'b0; samplePoint = 1'b1; canRX = 1'b1;
    tick();
    model_clear();
    n_total++;
    if (stuffing !== 1'b0 || bsError !== 1'b0)
      $display("FAIL disable_clear: got %b%b expected 00", stuffing, bsError);
    else n_pass++;
    bsOnOff = 1'b1;
    tick();
    samplePoint = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) do_sample(1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) do_sample(1'b0);
    n_total++;
    if (stuffing !== 1'b1) $display("FAIL pre_reset_stuff: got %b expected 1", stuffing);
    else n_pass++;
    #2;
    reset       = 1'b1;
    samplePoint = 1'b1;
    #1;
    model_clear();
    n_total++;
    if (stuffing !== 1'b0 || bsError !== 1'b0)
      $display("FAIL async_reset: got %b%b expected 00", stuffing, bsError);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    samplePoint = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) do_sample(1'b0);
    do_sample(1'b0);
  endtask

  initial begin
    test_reset();
    test_stuff_sequence();
    test_back_to_back();
    test_hold();
    test_disable();
    test_async_reset();
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
